// File: rtl/sdram_host_arbiter.sv
// Two-requester arbiter and sequencer for the SDRAM controller host port.
// Grants one single-word read or write at a time, round-robin on contention,
// issues a one-cycle enable pulse, follows controller busy to completion and
// returns a per-requester done pulse (with read data on reads).
module sdram_host_arbiter #(
    parameter int HADDR_WIDTH   = 24,
    parameter int DATA_WIDTH    = 16,
    parameter int START_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [HADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]  m0_wdata,
    output logic                   m0_ack,
    output logic                   m0_done,
    output logic [DATA_WIDTH-1:0]  m0_rdata,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [HADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]  m1_wdata,
    output logic                   m1_ack,
    output logic                   m1_done,
    output logic [DATA_WIDTH-1:0]  m1_rdata,
    output logic                   timeout_err,
    output logic [HADDR_WIDTH-1:0] haddr,
    output logic [DATA_WIDTH-1:0]  data_input,
    output logic                   rd_enable,
    output logic                   wr_enable,
    input  logic                   busy,
    input  logic [DATA_WIDTH-1:0]  data_output
);

    localparam int CNT_W = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_END   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   cur_q, cur_d;      // requester owning the current op
    logic                   we_q, we_d;        // current op is a write
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   ack0_q, ack0_d, ack1_q, ack1_d;
    logic                   done0_q, done0_d, done1_q, done1_d;
    logic [DATA_WIDTH-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                   tmo_q, tmo_d;

    logic                   win_s;             // requester that would win now
    logic                   grant_s;           // a grant happens on this edge
    logic                   cnt_full_s;

    // Round-robin winner selection and grant qualification.
    always_comb begin
        win_s = 1'b0;
        if (m0_req && m1_req) begin
            win_s = ~last_grant_q;
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        grant_s    = (state_q == S_IDLE) && !busy && (m0_req || m1_req);
        cnt_full_s = (cnt_q == CNT_W'(START_TIMEOUT));
    end

    // State register and all registered outputs; reset abandons any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cur_q        <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            haddr_q      <= '0;
            din_q        <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_q        <= cur_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            haddr_q      <= haddr_d;
            din_q        <= din_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            tmo_q        <= tmo_d;
        end
    end

    // Next-state logic for the grant/issue/wait sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (busy) begin
                    state_d = S_WAIT_END;
                end else if (cnt_full_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_END: begin
                if (!busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_END;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; pulses default low, data holds.
    always_comb begin
        last_grant_d = last_grant_q;
        cur_d        = cur_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        haddr_d      = haddr_q;
        din_d        = din_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        tmo_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_s) begin
                    haddr_d      = win_s ? m1_addr  : m0_addr;
                    din_d        = win_s ? m1_wdata : m0_wdata;
                    we_d         = win_s ? m1_we    : m0_we;
                    rd_en_d      = ~(win_s ? m1_we : m0_we);
                    wr_en_d      = win_s ? m1_we : m0_we;
                    ack0_d       = ~win_s;
                    ack1_d       = win_s;
                    last_grant_d = win_s;
                    cur_d        = win_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
            end
            S_WAIT_START: begin
                if (!busy && cnt_full_s) begin
                    tmo_d   = 1'b1;
                    done0_d = ~cur_q;
                    done1_d = cur_q;
                end else if (!busy) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WAIT_END: begin
                if (!busy) begin
                    done0_d = ~cur_q;
                    done1_d = cur_q;
                    if (!we_q && !cur_q) begin
                        rdata0_d = data_output;
                    end else if (!we_q && cur_q) begin
                        rdata1_d = data_output;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign m0_ack      = ack0_q;
    assign m1_ack      = ack1_q;
    assign m0_done     = done0_q;
    assign m1_done     = done1_q;
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;
    assign timeout_err = tmo_q;
    assign haddr       = haddr_q;
    assign data_input  = din_q;
    assign rd_enable   = rd_en_q;
    assign wr_enable   = wr_en_q;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed self-checking bench for sdram_host_arbiter. The bench plays the
// SDRAM controller by driving busy/data_output around each issued operation.
module tb_sdram_host_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_done, m1_ack, m1_done;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          timeout_err, rd_enable, wr_enable, busy;
    logic [AW-1:0] haddr;
    logic [DW-1:0] data_input, data_output;

    int checks   = 0;
    int failures = 0;

    sdram_host_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .timeout_err(timeout_err), .haddr(haddr), .data_input(data_input),
        .rd_enable(rd_enable), .wr_enable(wr_enable),
        .busy(busy), .data_output(data_output)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, expect the grant in the following cycle, drop the request.
    task automatic issue(input bit n, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (n) begin
            m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        end
        step();
        check_eq("ack", n ? m1_ack : m0_ack, 32'd1);
        check_eq("ack_other", n ? m0_ack : m1_ack, 32'd0);
        check_eq("wr_en", wr_enable, we);
        check_eq("rd_en", rd_enable, !we);
        check_eq("haddr", haddr, addr);
        check_eq("data_input", data_input, wd);
        if (n) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    // Starting in the issue cycle: busy rises bdelay cycles later for blen cycles.
    task automatic finish(input bit n, input bit we, input logic [DW-1:0] rdat,
                          input int bdelay, input int blen);
        step();
        check_eq("ack_pulse_end", m0_ack | m1_ack, 32'd0);
        check_eq("enable_pulse_end", rd_enable | wr_enable, 32'd0);
        for (int i = 1; i < bdelay; i++) step();
        busy = 1'b1;
        data_output = rdat;
        for (int i = 0; i < blen; i++) step();
        busy = 1'b0;
        check_eq("done_early", m0_done | m1_done, 32'd0);
        step();
        check_eq("done", n ? m1_done : m0_done, 32'd1);
        check_eq("done_other", n ? m0_done : m1_done, 32'd0);
        check_eq("no_timeout", timeout_err, 32'd0);
        if (!we) check_eq("rdata", n ? m1_rdata : m0_rdata, rdat);
    endtask

    // Abort if the run ever stalls far beyond its expected length.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int  wait_n;
        bit  got;
        bit  exp_n;
        rst_n = 1'b0; busy = 1'b0; data_output = '0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        step(); step();
        check_eq("rst_ack", {m0_ack, m1_ack, m0_done, m1_done}, 32'd0);
        check_eq("rst_en", {timeout_err, rd_enable, wr_enable}, 32'd0);
        check_eq("rst_haddr", haddr, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: m0 write, busy 3 cycles starting 1 cycle after wr_enable.
        issue(1'b0, 1'b1, 24'h00A55A, 16'hBEEF);
        finish(1'b0, 1'b1, 16'h0000, 1, 3);
        step();
        check_eq("done_one_cycle", m0_done, 32'd0);

        // 2: m1 read returning 0x1234; m0 side stays quiet.
        issue(1'b1, 1'b0, 24'h000123, 16'h0000);
        finish(1'b1, 1'b0, 16'h1234, 1, 2);
        check_eq("m0_rdata_static", m0_rdata, 32'd0);
        step();

        // 3: both hold requests for four transactions; grants alternate from m0.
        m0_we = 1'b1; m0_addr = 24'h000A00; m0_wdata = 16'h0A0A;
        m1_we = 1'b0; m1_addr = 24'h000B00; m1_wdata = 16'h0B0B;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            wait_n = 0;
            while (!got && wait_n < 10) begin
                step();
                wait_n++;
                got = m0_ack | m1_ack;
            end
            exp_n = k[0];
            check_eq("tie_ack_seen", got, 32'd1);
            check_eq("tie_latency", wait_n, 32'd1);
            check_eq("tie_m0_ack", m0_ack, !exp_n);
            check_eq("tie_m1_ack", m1_ack, exp_n);
            check_eq("one_enable", rd_enable & wr_enable, 32'd0);
            check_eq("tie_wr_en", wr_enable, !exp_n);
            check_eq("tie_haddr", haddr, exp_n ? 32'h000B00 : 32'h000A00);
            finish(exp_n, !exp_n, 16'h5A00 + 16'(k), 1, 2);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();

        // 4: controller busy (refresh) holds off the grant.
        busy = 1'b1;
        m0_we = 1'b0; m0_addr = 24'h000777; m0_wdata = 16'h0000; m0_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_ack", m0_ack, 32'd0);
            check_eq("stall_en", rd_enable | wr_enable, 32'd0);
        end
        busy = 1'b0;
        step();
        check_eq("stall_release_ack", m0_ack, 32'd1);
        check_eq("stall_release_rd", rd_enable, 32'd1);
        m0_req = 1'b0;
        finish(1'b0, 1'b0, 16'hC0DE, 1, 2);
        step();

        // 5: busy never rises -> timeout with done, rdata unchanged.
        issue(1'b0, 1'b0, 24'h000999, 16'h0000);
        got = 1'b0;
        wait_n = 0;
        while (!got && wait_n < 40) begin
            step();
            wait_n++;
            got = timeout_err;
        end
        check_eq("tmo_seen", got, 32'd1);
        check_eq("tmo_latency", wait_n, TO + 2);
        check_eq("tmo_done", m0_done, 32'd1);
        check_eq("tmo_rdata_held", m0_rdata, 32'hC0DE);
        step();
        check_eq("tmo_pulse", {timeout_err, m0_done}, 32'd0);
        issue(1'b0, 1'b1, 24'h000111, 16'h1111);
        finish(1'b0, 1'b1, 16'h0000, 1, 1);
        step();

        // 6: reset asserted in WAIT_END; outputs clear at once, m0 wins next tie.
        issue(1'b0, 1'b1, 24'h000ABC, 16'hABCD);
        step();
        busy = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_pulses", {m0_ack, m1_ack, m0_done, m1_done, timeout_err, rd_enable, wr_enable}, 32'd0);
        check_eq("async_rst_haddr", haddr, 32'd0);
        check_eq("async_rst_din", data_input, 32'd0);
        check_eq("async_rst_rdata", {m0_rdata, m1_rdata}, 32'd0);
        busy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m0_we = 1'b1; m0_addr = 24'h000321; m0_wdata = 16'h3210;
        m1_we = 1'b1; m1_addr = 24'h000654; m1_wdata = 16'h6540;
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        check_eq("post_rst_m0_wins", m0_ack, 32'd1);
        check_eq("post_rst_m1_waits", m1_ack, 32'd0);
        check_eq("post_rst_haddr", haddr, 32'h000321);
        m0_req = 1'b0; m1_req = 1'b0;
        finish(1'b0, 1'b1, 16'h0000, 1, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
